// File: rtl/br_svc_scheduler_pkg.sv
// Shared types for the BrLite service injection scheduler.
// Pure type/constant package: no latency, no flow control.
package br_svc_scheduler_pkg;

    localparam int BR_TS_W      = 32;
    localparam int BR_ID_W      = 16;
    localparam int BR_PAYLOAD_W = 32;

    typedef enum logic {
        BR_SVC_TGT = 1'b0,
        BR_SVC_ALL = 1'b1
    } br_svc_t;

    typedef struct packed {
        logic [BR_TS_W-1:0]      ts;
        logic [BR_ID_W-1:0]      tgt;
        logic [BR_PAYLOAD_W-1:0] payload;
        br_svc_t                 svc;
    } br_sched_rec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2
    } br_sched_state_t;

endpackage

// File: rtl/br_svc_scheduler_fifo.sv
// Synchronous FIFO of scheduler records with count; head visible combinationally.
// Latency: push visible at head next cycle; backpressure: full_o refuses push, even on a same-edge pop.
module br_sched_fifo
    import br_svc_scheduler_pkg::*;
#(
    parameter type T     = br_sched_rec_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  T                       push_dat_i,
    input  logic                   pop_i,
    output T                       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are never observable past empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/br_svc_scheduler.sv
// Releases queued timestamped service records to the BrLite router local port in FIFO order.
// Latency: due head requests 1 cycle after it becomes due; backpressure: push_ready_o=!full, br_req_o held until br_ack_i.
module br_svc_scheduler
    import br_svc_scheduler_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TS_W      = 32,
    parameter int ID_W      = 16,
    parameter int PAYLOAD_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ID_W-1:0]        src_id_i,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic [TS_W-1:0]        push_ts_i,
    input  logic [ID_W-1:0]        push_tgt_i,
    input  logic [PAYLOAD_W-1:0]   push_payload_i,
    input  br_svc_t                push_svc_i,
    output logic                   br_req_o,
    input  logic                   br_ack_i,
    output logic [ID_W-1:0]        br_src_o,
    output logic [ID_W-1:0]        br_tgt_o,
    output logic [PAYLOAD_W-1:0]   br_payload_o,
    output br_svc_t                br_svc_o,
    input  logic                   all_done_i,
    output logic [TS_W-1:0]        now_o,
    output logic [$clog2(DEPTH):0] pending_o,
    output logic [15:0]            late_cnt_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TS_W-1:0]      ts;
        logic [ID_W-1:0]      tgt;
        logic [PAYLOAD_W-1:0] payload;
        br_svc_t              svc;
    } rec_t;

    br_sched_state_t state_q, state_d;
    logic [TS_W-1:0] now_q, now_d;
    logic [15:0]     late_q, late_d;
    logic            all_pend_q, all_pend_d;

    rec_t            push_rec, head;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            push_acc, pop_en, head_due, head_blocked;
    logic [TS_W-1:0] age;

    assign push_rec = '{ts: push_ts_i, tgt: push_tgt_i, payload: push_payload_i, svc: push_svc_i};
    assign push_acc = push_valid_i && !fifo_full;
    assign pop_en   = (state_q == REQ) && br_ack_i && !fifo_empty;

    br_sched_fifo #(
        .T     (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push_valid_i),
        .push_dat_i (push_rec),
        .pop_i      (pop_en),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // Wrap-safe comparison: due when now is at most half the counter range past ts.
    assign age      = now_q - head.ts;
    assign head_due = !age[TS_W-1];
    // A completion pulse this cycle already unblocks, so release is not delayed a cycle.
    assign head_blocked = (head.svc == BR_SVC_ALL) && all_pend_q && !all_done_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (push_acc) state_d = WAIT;
            WAIT: if (head_due && !head_blocked) state_d = REQ;
            REQ: begin
                if (br_ack_i) begin
                    if (fifo_count == CW'(1) && !push_acc) state_d = IDLE;
                    else                                   state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        br_req_o     = (state_q == REQ);
        br_src_o     = '0;
        br_tgt_o     = '0;
        br_payload_o = '0;
        br_svc_o     = BR_SVC_TGT;
        if (state_q == REQ) begin
            br_src_o     = src_id_i;
            br_tgt_o     = head.tgt;
            br_payload_o = head.payload;
            br_svc_o     = head.svc;
        end
    end

    always_comb begin
        now_d      = now_q + 1'b1;
        late_d     = late_q;
        all_pend_d = all_pend_q;
        if (state_q == WAIT && state_d == REQ && now_q != head.ts && late_q != 16'hFFFF)
            late_d = late_q + 1'b1;
        if (pop_en && head.svc == BR_SVC_ALL) all_pend_d = 1'b1;
        else if (all_done_i)                  all_pend_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            now_q      <= '0;
            late_q     <= '0;
            all_pend_q <= 1'b0;
        end else begin
            now_q      <= now_d;
            late_q     <= late_d;
            all_pend_q <= all_pend_d;
        end
    end

    assign push_ready_o = !fifo_full;
    assign now_o        = now_q;
    assign pending_o    = fifo_count;
    assign late_cnt_o   = late_q;

endmodule

// File: tb/tb_br_svc_scheduler.sv
// Directed bench for br_svc_scheduler: release timing, head-of-line, ALL blocking, full queue, stall, reset.
module tb_br_svc_scheduler;
    import br_svc_scheduler_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [15:0]   src_id_i = 16'h0033;
    logic          push_valid_i = 1'b0;
    logic          push_ready_o;
    logic [31:0]   push_ts_i = '0;
    logic [15:0]   push_tgt_i = '0;
    logic [31:0]   push_payload_i = '0;
    br_svc_t       push_svc_i = BR_SVC_TGT;
    logic          br_req_o;
    logic          br_ack_i = 1'b0;
    logic [15:0]   br_src_o;
    logic [15:0]   br_tgt_o;
    logic [31:0]   br_payload_o;
    br_svc_t       br_svc_o;
    logic          all_done_i = 1'b0;
    logic [31:0]   now_o;
    logic [2:0]    pending_o;
    logic [15:0]   late_cnt_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    br_svc_scheduler #(.DEPTH(4), .TS_W(32), .ID_W(16), .PAYLOAD_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .src_id_i       (src_id_i),
        .push_valid_i   (push_valid_i),
        .push_ready_o   (push_ready_o),
        .push_ts_i      (push_ts_i),
        .push_tgt_i     (push_tgt_i),
        .push_payload_i (push_payload_i),
        .push_svc_i     (push_svc_i),
        .br_req_o       (br_req_o),
        .br_ack_i       (br_ack_i),
        .br_src_o       (br_src_o),
        .br_tgt_o       (br_tgt_o),
        .br_payload_o   (br_payload_o),
        .br_svc_o       (br_svc_o),
        .all_done_i     (all_done_i),
        .now_o          (now_o),
        .pending_o      (pending_o),
        .late_cnt_o     (late_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Cycle index: 0 in the cycle after reset is sampled.
    always @(posedge clk_i) begin
        if (rst_i) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d limit_reached", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        push_valid_i = 1'b0;
        br_ack_i     = 1'b0;
        all_done_i   = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input logic [31:0] ts, input logic [15:0] tgt,
                        input logic [31:0] pl, input br_svc_t svc);
        push_valid_i   = 1'b1;
        push_ts_i      = ts;
        push_tgt_i     = tgt;
        push_payload_i = pl;
        push_svc_i     = svc;
        step();
        push_valid_i = 1'b0;
    endtask

    task automatic ack();
        br_ack_i = 1'b1;
        step();
        br_ack_i = 1'b0;
    endtask

    task automatic wait_req(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            if (br_req_o) begin
                at = cyc;
                return;
            end
            step();
        end
        if (br_req_o) at = cyc;
    endtask

    typedef struct {
        logic [31:0] ts;
        logic [15:0] tgt;
        logic [31:0] payload;
        br_svc_t     svc;
        int          exp_cyc;
        int          exp_late;
    } vec_t;

    vec_t vt[4];
    int   at;
    int   early;

    initial begin
        // Head-of-line: 0xA7 (ts 410) waits behind 0xA4 (ts 420) and is late.
        vt[0] = '{ts: 420, tgt: 16'd5, payload: 32'hA4, svc: BR_SVC_TGT, exp_cyc: 421, exp_late: 0};
        vt[1] = '{ts: 410, tgt: 16'd5, payload: 32'hA7, svc: BR_SVC_TGT, exp_cyc: 423, exp_late: 1};
        vt[2] = '{ts: 423, tgt: 16'd7, payload: 32'hB1, svc: BR_SVC_TGT, exp_cyc: 425, exp_late: 2};
        vt[3] = '{ts: 500, tgt: 16'd9, payload: 32'hC3, svc: BR_SVC_ALL, exp_cyc: 501, exp_late: 2};

        // Reset values
        do_reset();
        chk("rst_req", br_req_o, 0);
        chk("rst_ready", push_ready_o, 1);
        chk("rst_now", now_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_late", late_cnt_o, 0);
        chk("rst_payload", br_payload_o, 0);

        // Single ALL record released exactly at its timestamp
        goto_cycle(10);
        chk("s1_now10", now_o, 10);
        push(32'd80, 16'd0, 32'h02, BR_SVC_ALL);
        chk("s1_pending", pending_o, 1);
        wait_req(200, at);
        chk("s1_req_cycle", at, 81);
        chk("s1_payload", br_payload_o, 32'h02);
        chk("s1_svc", br_svc_o, BR_SVC_ALL);
        chk("s1_src", br_src_o, 16'h0033);
        chk("s1_late", late_cnt_o, 0);
        ack();
        chk("s1_req_drop", br_req_o, 0);
        chk("s1_pending_after", pending_o, 0);

        // Table-driven release order and late counting
        do_reset();
        for (int i = 0; i < 4; i++) push(vt[i].ts, vt[i].tgt, vt[i].payload, vt[i].svc);
        chk("s2_pending_full", pending_o, 4);
        for (int i = 0; i < 4; i++) begin
            wait_req(600, at);
            chk($sformatf("s2_v%0d_cycle", i), at, vt[i].exp_cyc);
            chk($sformatf("s2_v%0d_payload", i), br_payload_o, vt[i].payload);
            chk($sformatf("s2_v%0d_tgt", i), br_tgt_o, vt[i].tgt);
            chk($sformatf("s2_v%0d_svc", i), br_svc_o, vt[i].svc);
            chk($sformatf("s2_v%0d_late", i), late_cnt_o, vt[i].exp_late);
            ack();
            chk($sformatf("s2_v%0d_drop", i), br_req_o, 0);
        end

        // Outstanding ALL blocks the next ALL and the TGT queued behind it
        do_reset();
        push(32'd4, 16'd0, 32'h01, BR_SVC_ALL);
        wait_req(50, at);
        chk("s3_first_cycle", at, 5);
        ack();
        push(32'd80, 16'd0, 32'h9F, BR_SVC_ALL);
        push(32'd90, 16'd3, 32'h5A, BR_SVC_TGT);
        early = 0;
        while (cyc < 120) begin
            if (br_req_o) early++;
            step();
        end
        chk("s3_blocked_no_req", early, 0);
        all_done_i = 1'b1;
        step();
        all_done_i = 1'b0;
        chk("s3_all_req", br_req_o, 1);
        chk("s3_all_payload", br_payload_o, 32'h9F);
        chk("s3_all_late", late_cnt_o, 1);
        ack();
        chk("s3_gap", br_req_o, 0);
        step();
        chk("s3_tgt_req", br_req_o, 1);
        chk("s3_tgt_payload", br_payload_o, 32'h5A);
        chk("s3_tgt_tgt", br_tgt_o, 3);
        chk("s3_tgt_late", late_cnt_o, 2);
        ack();

        // Full queue holds a fifth push, even across the pop edge
        do_reset();
        for (int i = 0; i < 4; i++) push(32'd1000, 16'h20 + 16'(i), 32'h10 + 32'(i), BR_SVC_TGT);
        chk("s4_ready_full", push_ready_o, 0);
        chk("s4_pending4", pending_o, 4);
        push_valid_i   = 1'b1;
        push_ts_i      = 32'd1000;
        push_tgt_i     = 16'h24;
        push_payload_i = 32'h14;
        push_svc_i     = BR_SVC_TGT;
        goto_cycle(1001);
        chk("s4_req", br_req_o, 1);
        chk("s4_payload0", br_payload_o, 32'h10);
        chk("s4_ready_at_ack", push_ready_o, 0);
        ack();
        chk("s4_ready_after", push_ready_o, 1);
        chk("s4_pending3", pending_o, 3);
        step();
        push_valid_i = 1'b0;
        chk("s4_pending_refill", pending_o, 4);
        chk("s4_req2", br_req_o, 1);
        chk("s4_payload1", br_payload_o, 32'h11);

        // Stalled request keeps every field stable
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("s5_hold_req_%0d", i), br_req_o, 1);
            chk($sformatf("s5_hold_pl_%0d", i), br_payload_o, 32'h11);
            chk($sformatf("s5_hold_tgt_%0d", i), br_tgt_o, 16'h21);
            chk($sformatf("s5_hold_src_%0d", i), br_src_o, 16'h0033);
        end
        ack();
        chk("s5_low_after_ack", br_req_o, 0);
        chk("s5_pending", pending_o, 3);
        step();
        chk("s5_next_req", br_req_o, 1);
        chk("s5_next_payload", br_payload_o, 32'h12);

        // Reset while requesting
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("s6_req", br_req_o, 0);
        chk("s6_ready", push_ready_o, 1);
        chk("s6_now", now_o, 0);
        chk("s6_pending", pending_o, 0);
        chk("s6_late", late_cnt_o, 0);
        chk("s6_tgt", br_tgt_o, 0);
        for (int i = 0; i < 5; i++) step();
        chk("s6_now5", now_o, 5);
        chk("s6_req_idle", br_req_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
